reg_rename_file: RTL and testbench
==================================

Name: reg_rename_file

Overview:
- Architectural register file with per-register rename tags. It is the consumer end of the ROB commit/dependency interface.
- Dispatch renames a destination register to a ROB tag. Operand reads return the value and the producing ROB tag (`rs*_rely`) that the ROB and RS use to resolve operands.
- ROB commits retire values into the file and release matching tags. A ROB clear drops all in-flight renames.

Parameters:
- REG_NUM, 32, number of architectural registers; x0 is hardwired to zero.
- XLEN, 32, register value width.
- TAG_W, 5, ROB tag width; tag 0 means "no pending producer"; valid ROB tags are 1..16.

Ports:
- clk_in  input  1  clock, rising-edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global enable; when low, all state holds.
- rs1_addr  input  5  operand-1 register index, from dispatch.
- rs2_addr  input  5  operand-2 register index, from dispatch.
- rs1_val  output  XLEN  operand-1 committed value (combinational).
- rs2_val  output  XLEN  operand-2 committed value (combinational).
- rs1_rely  output  TAG_W  ROB tag producing rs1; 0 means rs1_val is final (combinational).
- rs2_rely  output  TAG_W  ROB tag producing rs2; 0 means rs2_val is final (combinational).
- dispatch_rdy  input  1  one instruction is dispatched this cycle.
- dispatch_rd  input  5  destination register of the dispatched instruction; 0 means no rd.
- dispatch_tag  input  TAG_W  ROB tag allocated to it (ROB_next_tag).
- write_rdy  input  1  ROB commit writes a register this cycle.
- to_rd  input  5  commit destination register.
- write_val  input  XLEN  commit value.
- head_tag  input  TAG_W  ROB tag of the committing entry.
- clear  input  1  ROB mispredict flush.
- busy_cnt  output  6  registered count of registers with a nonzero tag, for debug and perf.

Behaviour:
- Reset (rst_in=0, asynchronous): all values = 0, all tags = 0, busy_cnt = 0. As a result rs*_val = 0 and rs*_rely = 0. Reset asserted mid-operation discards all pending renames immediately.
- Read path (combinational, from current state, with commit bypass):
  - Default: rsN_val = val[rsN_addr], rsN_rely = tag[rsN_addr].
  - Bypass: if write_rdy && to_rd==rsN_addr && to_rd!=0 && tag[to_rd]==head_tag, then rsN_val = write_val and rsN_rely = 0. This covers the freed ROB entry, which is no longer readable in the ROB.
  - rsN_addr==0 gives val 0 and rely 0.
  - A same-cycle dispatch to a register equal to rsN_addr does not affect the read; the read sees the pre-rename mapping.
- Sequential update at posedge clk_in, only when rdy_in=1, in this priority:
  1. Commit: if write_rdy && to_rd!=0, then val[to_rd] <= write_val. If tag[to_rd]==head_tag, tag[to_rd] <= 0. A mismatching tag means a younger rename exists and the tag is kept.
  2. Clear: if clear=1, all tags <= 0 and dispatch is ignored this cycle. The commit in step 1 is still applied, because the flushing instruction itself retires.
  3. Dispatch: if dispatch_rdy && !clear && dispatch_rd!=0, then tag[dispatch_rd] <= dispatch_tag. This overrides a same-cycle commit tag release on the same register.
  4. busy_cnt <= number of nonzero tags after steps 1-3.
- dispatch_tag==0 with dispatch_rdy is illegal; the bench flags it as an assertion.
- x0: writes and renames are ignored; value and tag stay 0 at all times.
- rdy_in=0: no state change, and reads stay live.
- Latency:
  - A rename is visible on rs*_rely the cycle after dispatch.
  - A commit value is visible the same cycle via bypass, and from state in the following cycle.

Test Plan:
- Reset, then read x5 and x0 -> val=0, rely=0, busy_cnt=0. Assert rst_in low mid-run with 3 renames pending -> all tags 0 immediately.
- Dispatch rd=x3 tag=4; next cycle read x3 -> rely=4, busy_cnt=1. Commit to_rd=3, head_tag=4, val=0xDEAD in that cycle -> same-cycle read gives val=0xDEAD, rely=0. Next cycle: state val=0xDEAD, tag=0.
- x3 renamed tag=4, then tag=7. Commit to_rd=3, head_tag=4, val=11 -> val[3]=11, tag stays 7, read x3 gives rely=7.
- In the same cycle, commit x6 (tag 2) and dispatch rd=x6 tag=9 -> val[6] updated, tag[6]=9.
- Renames on x1 (tag 2), x2 (tag 3), x4 (tag 5). Then clear=1 together with a commit to x1 (val=5, head_tag=2) and a dispatch rd=x8 -> all tags 0, val[1]=5, tag[8] stays 0, busy_cnt=0.
- Hold rdy_in=0 while driving a commit and a dispatch -> no state change. Dispatch rd=0 tag=3 -> x0 tag stays 0.

Source files
------------

// File: rtl/reg_rename_file_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_rename_file_if
// Purpose  : Dispatch / operand-read / ROB-commit bundle for reg_rename_file.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_rename_file_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic [4:0]       rs1_addr;
   logic [4:0]       rs2_addr;
   logic [XLEN-1:0]  rs1_val;
   logic [XLEN-1:0]  rs2_val;
   logic [TAG_W-1:0] rs1_rely;
   logic [TAG_W-1:0] rs2_rely;
   logic             dispatch_rdy;
   logic [4:0]       dispatch_rd;
   logic [TAG_W-1:0] dispatch_tag;
   logic             write_rdy;
   logic [4:0]       to_rd;
   logic [XLEN-1:0]  write_val;
   logic [TAG_W-1:0] head_tag;
   logic             clear;
   logic [5:0]       busy_cnt;

   modport master (
      output rs1_addr, rs2_addr, dispatch_rdy, dispatch_rd, dispatch_tag,
             write_rdy, to_rd, write_val, head_tag, clear,
      input  rs1_val, rs2_val, rs1_rely, rs2_rely, busy_cnt
   );

   modport slave (
      input  rs1_addr, rs2_addr, dispatch_rdy, dispatch_rd, dispatch_tag,
             write_rdy, to_rd, write_val, head_tag, clear,
      output rs1_val, rs2_val, rs1_rely, rs2_rely, busy_cnt
   );
endinterface
`default_nettype wire

// File: rtl/reg_rename_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_rename_file
// Purpose  : Architectural register file with per-register ROB rename tags.
// Revision : 1.0 - initial release
// ============================================================================
module reg_rename_file #(
   parameter int REG_NUM = 32,
   parameter int XLEN    = 32,
   parameter int TAG_W   = 5
) (
   input  wire              clk_in,
   input  wire              rst_in,
   input  wire              rdy_in,
   reg_rename_file_if.slave bus
);
   logic [XLEN-1:0]  val_q [REG_NUM];
   logic [XLEN-1:0]  val_d [REG_NUM];
   logic [TAG_W-1:0] tag_q [REG_NUM];
   logic [TAG_W-1:0] tag_d [REG_NUM];
   logic [5:0]       busy_cnt_q;
   logic [5:0]       busy_cnt_d;

   logic w_commit;
   logic w_release;

   assign w_commit  = bus.write_rdy && (bus.to_rd != 5'd0);
   assign w_release = w_commit && (tag_q[bus.to_rd] == bus.head_tag);

   // The committing ROB entry is freed this cycle, so its value must come from here.
   always_comb begin
      bus.rs1_val  = val_q[bus.rs1_addr];
      bus.rs1_rely = tag_q[bus.rs1_addr];
      if (w_release && (bus.to_rd == bus.rs1_addr)) begin
         bus.rs1_val  = bus.write_val;
         bus.rs1_rely = '0;
      end
   end

   always_comb begin
      bus.rs2_val  = val_q[bus.rs2_addr];
      bus.rs2_rely = tag_q[bus.rs2_addr];
      if (w_release && (bus.to_rd == bus.rs2_addr)) begin
         bus.rs2_val  = bus.write_val;
         bus.rs2_rely = '0;
      end
   end

   always_comb begin
      val_d      = val_q;
      tag_d      = tag_q;
      busy_cnt_d = 6'd0;
      if (w_commit) begin
         val_d[bus.to_rd] = bus.write_val;
         if (w_release)
            tag_d[bus.to_rd] = '0;
      end
      if (bus.clear) begin
         for (int i = 0; i < REG_NUM; i++)
            tag_d[i] = '0;
      end else if (bus.dispatch_rdy && (bus.dispatch_rd != 5'd0)) begin
         tag_d[bus.dispatch_rd] = bus.dispatch_tag;
      end
      val_d[0] = '0;
      tag_d[0] = '0;
      for (int i = 0; i < REG_NUM; i++)
         if (tag_d[i] != '0)
            busy_cnt_d = busy_cnt_d + 6'd1;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < REG_NUM; i++) begin
            val_q[i] <= '0;
            tag_q[i] <= '0;
         end
         busy_cnt_q <= 6'd0;
      end else if (rdy_in) begin
         val_q      <= val_d;
         tag_q      <= tag_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign bus.busy_cnt = busy_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_reg_rename_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_rename_file
// Purpose  : Directed self-checking bench for reg_rename_file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_rename_file;
   logic clk_in = 1'b0;
   logic rst_in = 1'b0;
   logic rdy_in = 1'b0;
   int   n_cmp  = 0;
   int   n_err  = 0;

   reg_rename_file_if #(.XLEN(32), .TAG_W(5)) bus ();

   reg_rename_file #(.REG_NUM(32), .XLEN(32), .TAG_W(5)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .rdy_in (rdy_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in)
      if (rst_in && rdy_in && bus.dispatch_rdy)
         assert (bus.dispatch_tag != 5'd0) else $error("illegal dispatch_tag 0");

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle();
      bus.dispatch_rdy = 1'b0;
      bus.dispatch_rd  = 5'd0;
      bus.dispatch_tag = 5'd0;
      bus.write_rdy    = 1'b0;
      bus.to_rd        = 5'd0;
      bus.write_val    = 32'd0;
      bus.head_tag     = 5'd0;
      bus.clear        = 1'b0;
   endtask

   task automatic disp(input logic [4:0] rd, input logic [4:0] tg);
      bus.dispatch_rdy = 1'b1;
      bus.dispatch_rd  = rd;
      bus.dispatch_tag = tg;
   endtask

   task automatic commit(input logic [4:0] rd, input logic [4:0] ht, input logic [31:0] v);
      bus.write_rdy = 1'b1;
      bus.to_rd     = rd;
      bus.head_tag  = ht;
      bus.write_val = v;
   endtask

   task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
      bus.rs1_addr = a1;
      bus.rs2_addr = a2;
      #1;
   endtask

   initial begin
      idle();
      rd(5'd5, 5'd0);
      #12 rst_in = 1'b1;
      rdy_in = 1'b1;
      step();
      chk("rst_x5_val", bus.rs1_val, 0);
      chk("rst_x5_rely", 32'(bus.rs1_rely), 0);
      chk("rst_x0_val", bus.rs2_val, 0);
      chk("rst_x0_rely", 32'(bus.rs2_rely), 0);
      chk("rst_busy", 32'(bus.busy_cnt), 0);

      // rename then same-cycle commit bypass
      disp(5'd3, 5'd4); step(); idle();
      rd(5'd3, 5'd3);
      chk("ren_x3_rely", 32'(bus.rs1_rely), 4);
      chk("ren_busy", 32'(bus.busy_cnt), 1);
      commit(5'd3, 5'd4, 32'hDEAD); rd(5'd3, 5'd3);
      chk("byp_val", bus.rs1_val, 32'hDEAD);
      chk("byp_rely", 32'(bus.rs2_rely), 0);
      step(); idle(); rd(5'd3, 5'd3);
      chk("st_val", bus.rs1_val, 32'hDEAD);
      chk("st_rely", 32'(bus.rs1_rely), 0);
      chk("st_busy", 32'(bus.busy_cnt), 0);

      // stale commit keeps the younger tag
      disp(5'd3, 5'd4); step(); disp(5'd3, 5'd7); step(); idle();
      rd(5'd3, 5'd3);
      chk("young_rely", 32'(bus.rs1_rely), 7);
      commit(5'd3, 5'd4, 32'd11); rd(5'd3, 5'd3);
      chk("nobyp_val", bus.rs1_val, 32'hDEAD);
      chk("nobyp_rely", 32'(bus.rs1_rely), 7);
      step(); idle(); rd(5'd3, 5'd3);
      chk("stale_val", bus.rs1_val, 11);
      chk("stale_rely", 32'(bus.rs1_rely), 7);
      chk("stale_busy", 32'(bus.busy_cnt), 1);

      // commit and dispatch on the same register
      disp(5'd6, 5'd2); step(); idle();
      commit(5'd6, 5'd2, 32'h66); disp(5'd6, 5'd9); step(); idle();
      rd(5'd3, 5'd6);
      chk("cd_val", bus.rs2_val, 32'h66);
      chk("cd_rely", 32'(bus.rs2_rely), 9);
      chk("cd_busy", 32'(bus.busy_cnt), 2);

      // clear with commit and ignored dispatch
      disp(5'd1, 5'd2); step(); disp(5'd2, 5'd3); step(); disp(5'd4, 5'd5); step(); idle();
      rd(5'd2, 5'd4);
      chk("pre_clr_busy", 32'(bus.busy_cnt), 5);
      chk("pre_clr_x4", 32'(bus.rs2_rely), 5);
      bus.clear = 1'b1; commit(5'd1, 5'd2, 32'd5); disp(5'd8, 5'd10); step(); idle();
      rd(5'd1, 5'd8);
      chk("clr_x1_val", bus.rs1_val, 5);
      chk("clr_x1_rely", 32'(bus.rs1_rely), 0);
      chk("clr_x8_rely", 32'(bus.rs2_rely), 0);
      chk("clr_busy", 32'(bus.busy_cnt), 0);
      rd(5'd3, 5'd6);
      chk("clr_x3_rely", 32'(bus.rs1_rely), 0);
      chk("clr_x6_rely", 32'(bus.rs2_rely), 0);

      // rdy_in low freezes state, reads stay live
      disp(5'd5, 5'd3); step(); idle();
      rdy_in = 1'b0;
      commit(5'd5, 5'd3, 32'h55); disp(5'd9, 5'd11); rd(5'd5, 5'd9);
      chk("hold_byp_val", bus.rs1_val, 32'h55);
      chk("hold_byp_rely", 32'(bus.rs1_rely), 0);
      step(); step(); idle(); rdy_in = 1'b1; rd(5'd5, 5'd9);
      chk("hold_x5_val", bus.rs1_val, 0);
      chk("hold_x5_rely", 32'(bus.rs1_rely), 3);
      chk("hold_x9_rely", 32'(bus.rs2_rely), 0);
      chk("hold_busy", 32'(bus.busy_cnt), 1);

      // x0 ignores renames and writes
      disp(5'd0, 5'd3); commit(5'd0, 5'd0, 32'h77); rd(5'd0, 5'd0);
      chk("x0_byp_val", bus.rs1_val, 0);
      step(); idle(); rd(5'd0, 5'd0);
      chk("x0_val", bus.rs1_val, 0);
      chk("x0_rely", 32'(bus.rs2_rely), 0);
      chk("x0_busy", 32'(bus.busy_cnt), 1);

      // asynchronous reset with renames pending
      disp(5'd10, 5'd1); step(); disp(5'd11, 5'd2); step(); idle();
      rd(5'd10, 5'd11);
      chk("pre_rst_busy", 32'(bus.busy_cnt), 3);
      chk("pre_rst_x11", 32'(bus.rs2_rely), 2);
      #2 rst_in = 1'b0;
      rd(5'd10, 5'd5);
      chk("arst_x10_rely", 32'(bus.rs1_rely), 0);
      chk("arst_x5_rely", 32'(bus.rs2_rely), 0);
      chk("arst_busy", 32'(bus.busy_cnt), 0);
      rd(5'd1, 5'd3);
      chk("arst_x1_val", bus.rs1_val, 0);
      chk("arst_x3_val", bus.rs2_val, 0);
      #3 rst_in = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
